// File: rtl/tone_voice.sv
// Monophonic square-wave voice: note bus in, envelope-shaped signed samples out.
// State | meaning
// IDLE    | silent, waiting for a nonzero note
// ATTACK  | amplitude ramping up toward full scale
// SUSTAIN | amplitude held at full scale while the note stays on
// RELEASE | amplitude ramping down after the note is released
module tone_voice #(
   parameter logic [15:0] MIN_HALF     = 16'd16,
   parameter logic [19:0] ENV_DIV      = 20'd50000,
   parameter logic [10:0] SAMPLE_DIV   = 11'd1042,
   parameter logic [7:0]  ATTACK_STEP  = 8'd16,
   parameter logic [7:0]  RELEASE_STEP = 8'd8
) (
   input  logic        clk50,
   input  logic        reset,
   input  logic [15:0] note_in,
   output logic        square_out,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   output logic        busy,
   output logic [7:0]  amp
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ATTACK  = 2'd1;
   localparam logic [1:0] S_SUSTAIN = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]  state;
   logic [15:0] note_q;
   logic [15:0] eff;
   logic [15:0] cur_half;
   logic [15:0] pend_half;
   logic [15:0] hp_cnt;
   logic [19:0] env_cnt;
   logic [10:0] smp_cnt;
   logic        env_tick;
   logic        hp_edge;
   logic        smp_wrap;
   logic [8:0]  amp_up;
   logic [7:0]  amp_up_sat;
   logic [7:0]  amp_dn;
   logic [15:0] mag;

   always_comb begin
      eff        = (note_q != 16'd0 && note_q < MIN_HALF) ? MIN_HALF : note_q;
      env_tick   = (env_cnt == ENV_DIV - 20'd1);
      hp_edge    = (hp_cnt == cur_half - 16'd1);
      smp_wrap   = (smp_cnt == SAMPLE_DIV - 11'd1);
      amp_up     = {1'b0, amp} + {1'b0, ATTACK_STEP};
      amp_up_sat = amp_up[8] ? 8'hFF : amp_up[7:0];
      amp_dn     = (amp > RELEASE_STEP) ? (amp - RELEASE_STEP) : 8'd0;
      // amp<<7 tops out at 32640, so the negation always fits in 16 bits
      mag        = {1'b0, amp, 7'd0};
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk50) begin
      if (reset) begin
         state        <= S_IDLE;
         note_q       <= 16'd0;
         cur_half     <= 16'd0;
         pend_half    <= 16'd0;
         hp_cnt       <= 16'd0;
         env_cnt      <= 20'd0;
         smp_cnt      <= 11'd0;
         square_out   <= 1'b0;
         sample_out   <= 16'd0;
         sample_valid <= 1'b0;
         amp          <= 8'd0;
      end else begin
         note_q <= note_in;

         env_cnt <= env_tick ? 20'd0 : env_cnt + 20'd1;

         smp_cnt      <= smp_wrap ? 11'd0 : smp_cnt + 11'd1;
         sample_valid <= smp_wrap;
         if (smp_wrap)
            sample_out <= square_out ? mag : (16'd0 - mag);

         if (eff != 16'd0)
            pend_half <= eff;

         // pitch only changes on an edge, so every half-period runs to completion
         if (state != S_IDLE) begin
            if (hp_edge) begin
               hp_cnt     <= 16'd0;
               square_out <= ~square_out;
               cur_half   <= pend_half;
            end else begin
               hp_cnt <= hp_cnt + 16'd1;
            end
         end

         case (state)
            S_IDLE: begin
               if (eff != 16'd0) begin
                  state     <= S_ATTACK;
                  cur_half  <= eff;
                  pend_half <= eff;
                  hp_cnt    <= 16'd0;
               end
            end
            S_ATTACK: begin
               if (env_tick)
                  amp <= amp_up_sat;
               if (eff == 16'd0)
                  state <= S_RELEASE;
               else if (amp == 8'hFF)
                  state <= S_SUSTAIN;
            end
            S_SUSTAIN: begin
               if (eff == 16'd0)
                  state <= S_RELEASE;
            end
            S_RELEASE: begin
               if (env_tick)
                  amp <= amp_dn;
               if (eff != 16'd0) begin
                  state <= S_ATTACK;
               end else if (amp == 8'd0) begin
                  state      <= S_IDLE;
                  square_out <= 1'b0;
                  hp_cnt     <= 16'd0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tone_voice.sv
// Self-checking bench for tone_voice with short envelope and sample dividers.
module tb_tone_voice;

   logic        clk50;
   logic        reset;
   logic [15:0] note_in;
   logic        square_out;
   logic [15:0] sample_out;
   logic        sample_valid;
   logic        busy;
   logic [7:0]  amp;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   tone_voice #(
      .MIN_HALF    (16'd16),
      .ENV_DIV     (20'd4),
      .SAMPLE_DIV  (11'd8),
      .ATTACK_STEP (8'd16),
      .RELEASE_STEP(8'd8)
   ) dut (
      .clk50       (clk50),
      .reset       (reset),
      .note_in     (note_in),
      .square_out  (square_out),
      .sample_out  (sample_out),
      .sample_valid(sample_valid),
      .busy        (busy),
      .amp         (amp)
   );

   initial clk50 = 1'b0;
   always #5 clk50 = ~clk50;

   // Counts negedges until square_out changes; n = -1 if the limit expires.
   task automatic wait_toggle(input int limit, output int n);
      logic prev;
      bit   done;
      prev = square_out;
      done = 0;
      n    = 0;
      while (!done && n < limit) begin
         @(negedge clk50);
         n++;
         if (square_out !== prev) done = 1;
      end
      if (!done) n = -1;
   endtask

   task automatic start_note(input logic [15:0] note);
      reset   = 1'b1;
      note_in = note;
      repeat (2) @(negedge clk50);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      note_in = 16'd100;
      repeat (3) @(negedge clk50);
      n_checks++; if (square_out !== 1'b0) begin n_fail++; $display("FAIL rst_square got=%0b want=0", square_out); end
      n_checks++; if (sample_out !== 16'd0) begin n_fail++; $display("FAIL rst_sample got=%h want=0000", sample_out); end
      n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b want=0", sample_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b want=0", busy); end
      n_checks++; if (amp !== 8'd0) begin n_fail++; $display("FAIL rst_amp got=%0d want=0", amp); end
      reset = 1'b0;
      @(negedge clk50);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_lat1 got=%0b want=0", busy); end
      @(negedge clk50);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_lat2 got=%0b want=1", busy); end
      // envelope ticks land 4, 8 and 12 cycles after release, all in ATTACK
      repeat (10) @(negedge clk50);
      n_checks++; if (amp !== 8'd48) begin n_fail++; $display("FAIL attack_amp48 got=%0d want=48", amp); end
      reset = 1'b1;
      @(negedge clk50);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rerst_busy got=%0b want=0", busy); end
      n_checks++; if (amp !== 8'd0) begin n_fail++; $display("FAIL rerst_amp got=%0d want=0", amp); end
      n_checks++; if (square_out !== 1'b0) begin n_fail++; $display("FAIL rerst_square got=%0b want=0", square_out); end
      n_checks++; if (sample_out !== 16'd0 || sample_valid !== 1'b0) begin
         n_fail++; $display("FAIL rerst_sample got=%h/%0b want=0000/0", sample_out, sample_valid);
      end
   endtask

   task automatic test_pitch;
      int n;
      int e;
      start_note(16'd100);
      exp_q.delete();
      exp_q.push_back(102);
      for (int i = 0; i < 20; i++) exp_q.push_back(100);
      while (exp_q.size() > 0) begin
         wait_toggle(250, n);
         e = exp_q.pop_front();
         n_checks++; if (n !== e) begin n_fail++; $display("FAIL pitch_half got=%0d want=%0d", n, e); end
      end
   endtask

   task automatic test_attack;
      logic [7:0] prev_amp;
      logic       sq_prev;
      int         e;
      int         cyc;
      int         last_strobe;
      int         bad;
      bit         seen_pos;
      bit         seen_neg;
      logic [15:0] want;
      start_note(16'd100);
      exp_q.delete();
      for (int i = 1; i <= 15; i++) exp_q.push_back(16 * i);
      exp_q.push_back(255);
      prev_amp = amp;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
         @(negedge clk50);
         cyc++;
         if (amp !== prev_amp) begin
            e = exp_q.pop_front();
            n_checks++; if (amp !== e[7:0]) begin n_fail++; $display("FAIL attack_step got=%0d want=%0d", amp, e); end
            prev_amp = amp;
         end
      end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL attack_timeout got=%0d left want=0", exp_q.size()); end
      bad = 0;
      repeat (20) begin
         @(negedge clk50);
         if (amp !== 8'hFF || busy !== 1'b1) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sustain_hold got=%0d bad cycles want=0", bad); end
      seen_pos = 0;
      seen_neg = 0;
      last_strobe = -1;
      sq_prev = square_out;
      for (int c = 0; c < 240; c++) begin
         @(negedge clk50);
         if (sample_valid === 1'b1) begin
            want = sq_prev ? 16'h7F80 : 16'h8080;
            if (sq_prev) seen_pos = 1; else seen_neg = 1;
            n_checks++; if (sample_out !== want) begin n_fail++; $display("FAIL sustain_sample got=%h want=%h", sample_out, want); end
            if (last_strobe >= 0) begin
               n_checks++; if (c - last_strobe != 8) begin n_fail++; $display("FAIL strobe_gap got=%0d want=8", c - last_strobe); end
            end
            last_strobe = c;
         end
         sq_prev = square_out;
      end
      n_checks++; if (!(seen_pos && seen_neg)) begin n_fail++; $display("FAIL sample_polarity got=%0b%0b want=11", seen_pos, seen_neg); end
   endtask

   task automatic test_glitch_free;
      int n;
      int e;
      wait_toggle(250, n);
      repeat (30) @(negedge clk50);
      note_in = 16'd50;
      exp_q.delete();
      exp_q.push_back(70);
      for (int i = 0; i < 6; i++) exp_q.push_back(50);
      while (exp_q.size() > 0) begin
         wait_toggle(250, n);
         e = exp_q.pop_front();
         n_checks++; if (n !== e) begin n_fail++; $display("FAIL glitch_half got=%0d want=%0d", n, e); end
      end
   endtask

   task automatic test_release;
      logic [7:0] prev_amp;
      int e;
      int cyc;
      bit found;
      note_in = 16'd0;
      exp_q.delete();
      for (int i = 1; i <= 31; i++) exp_q.push_back(255 - 8 * i);
      exp_q.push_back(0);
      prev_amp = amp;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 300) begin
         @(negedge clk50);
         cyc++;
         if (amp !== prev_amp) begin
            e = exp_q.pop_front();
            n_checks++; if (amp !== e[7:0]) begin n_fail++; $display("FAIL release_step got=%0d want=%0d", amp, e); end
            prev_amp = amp;
         end
      end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL release_timeout got=%0d left want=0", exp_q.size()); end
      @(negedge clk50);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%0b want=0", busy); end
      n_checks++; if (square_out !== 1'b0) begin n_fail++; $display("FAIL idle_square got=%0b want=0", square_out); end
      found = 0;
      for (int c = 0; c < 16 && !found; c++) begin
         @(negedge clk50);
         if (sample_valid === 1'b1) found = 1;
      end
      n_checks++; if (!found || sample_out !== 16'd0) begin
         n_fail++; $display("FAIL idle_sample got=%h valid=%0b want=0000", sample_out, found);
      end
   endtask

   task automatic test_retrigger;
      logic [7:0] prev_amp;
      int e;
      int cyc;
      bit found;
      note_in = 16'd100;
      cyc = 0;
      while (amp !== 8'hFF && cyc < 200) begin @(negedge clk50); cyc++; end
      n_checks++; if (amp !== 8'hFF) begin n_fail++; $display("FAIL retrig_full got=%0d want=255", amp); end
      note_in = 16'd0;
      found = 0;
      cyc = 0;
      while (!found && cyc < 300) begin
         @(negedge clk50);
         cyc++;
         if (amp === 8'd127) found = 1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL retrig_127 got=%0d want=127", amp); end
      note_in = 16'd100;
      exp_q.delete();
      exp_q.push_back(143);
      exp_q.push_back(159);
      prev_amp = amp;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 40) begin
         @(negedge clk50);
         cyc++;
         if (amp !== prev_amp) begin
            e = exp_q.pop_front();
            n_checks++; if (amp !== e[7:0]) begin n_fail++; $display("FAIL retrig_step got=%0d want=%0d", amp, e); end
            prev_amp = amp;
         end
      end
      n_checks++; if (exp_q.size() != 0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL retrig_timeout got=%0d left busy=%0b want=0 left busy=1", exp_q.size(), busy);
      end
   endtask

   task automatic test_clamp;
      logic [15:0] notes [3];
      int          want  [3];
      int n;
      int e;
      notes[0] = 16'd3;  want[0] = 16;
      notes[1] = 16'd16; want[1] = 16;
      notes[2] = 16'd17; want[2] = 17;
      for (int k = 0; k < 3; k++) begin
         note_in = notes[k];
         repeat (3) wait_toggle(250, n);
         exp_q.delete();
         for (int i = 0; i < 4; i++) exp_q.push_back(want[k]);
         while (exp_q.size() > 0) begin
            wait_toggle(250, n);
            e = exp_q.pop_front();
            n_checks++; if (n !== e) begin
               n_fail++; $display("FAIL clamp_half note=%0d got=%0d want=%0d", notes[k], n, e);
            end
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      note_in = 16'd0;
      test_reset;
      test_pitch;
      test_attack;
      test_glitch_free;
      test_release;
      test_retrigger;
      test_clamp;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
